// File: rtl/wb_wavelet_bridge.sv
// Wishbone classic responder that streams 8-bit samples to the wavelet core
// through a first-word-fall-through FIFO and captures the core's results.
//
// state  | meaning
// S_IDLE | waiting for an in-window strobe; register side effects commit on exit
// S_ACK  | ack high for one cycle with registered read data
// S_WAIT | hold until the strobe drops so each strobe receives one ack

module wb_wavelet_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  sample_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    input  logic [7:0]  result_i,
    input  logic        result_valid_i,
    output logic        irq_o
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic   w_ack, w_take, w_req;

    logic             r_enable, r_irq_en, r_overflow, r_res_valid, r_res_lost;
    logic [7:0]       r_result;
    logic [31:0]      r_dat;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [1:0]  w_off;
    logic        w_wr, w_rd, w_ctrl_wr, w_flush, w_stat_wr, w_push, w_res_rd;
    logic        w_empty, w_full, w_valid, w_pop, w_push_ok, w_ovf_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_take      = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_req) begin
                w_take      = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (!wbs_stb_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_off     = wbs_adr_i[3:2];
    assign w_wr      = w_take & wbs_we_i & wbs_sel_i[0];
    assign w_rd      = w_take & ~wbs_we_i;
    assign w_ctrl_wr = w_wr & (w_off == 2'd0);
    assign w_flush   = w_ctrl_wr & wbs_dat_i[1];
    assign w_stat_wr = w_wr & (w_off == 2'd1);
    assign w_push    = w_wr & (w_off == 2'd2);
    assign w_res_rd  = w_rd & (w_off == 2'd3);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_valid   = r_enable & ~w_empty;
    assign w_pop     = w_valid & sample_ready_i;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= wbs_dat_i[7:0];
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_enable    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_overflow  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_lost  <= 1'b0;
            r_result    <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= wbs_dat_i[0];
                r_irq_en <= wbs_dat_i[2];
            end
            if (w_ovf_set)                          r_overflow <= 1'b1;
            else if (w_stat_wr && wbs_dat_i[11])    r_overflow <= 1'b0;
            // A result landing with the RESULT read replaces the value without loss.
            if (result_valid_i) begin
                r_result    <= result_i;
                r_res_valid <= 1'b1;
            end else if (w_res_rd) begin
                r_res_valid <= 1'b0;
            end
            if (result_valid_i && r_res_valid && !w_res_rd) r_res_lost <= 1'b1;
            else if (w_stat_wr && wbs_dat_i[12])            r_res_lost <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (w_off)
            2'd0: begin
                w_rdata[0] = r_enable;
                w_rdata[2] = r_irq_en;
            end
            2'd1: begin
                w_rdata[7:0] = 8'(r_count);
                w_rdata[8]   = w_empty;
                w_rdata[9]   = w_full;
                w_rdata[10]  = r_res_valid;
                w_rdata[11]  = r_overflow;
                w_rdata[12]  = r_res_lost;
            end
            2'd3:    w_rdata[7:0] = r_result;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_dat <= '0;
        else          r_dat <= w_rd ? w_rdata : '0;
    end

    assign wbs_ack_o      = w_ack;
    assign wbs_dat_o      = r_dat;
    assign sample_o       = r_mem[r_rd_ptr];
    assign sample_valid_o = w_valid;
    assign irq_o          = r_irq_en & r_res_valid;

    assign w_unused = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:13], wbs_dat_i[10:8]};

endmodule

// File: tb/tb_wb_wavelet_bridge.sv
// Bench for wb_wavelet_bridge: directed scenarios plus randomized bus traffic,
// every cycle compared against a queue-based reference model.

module tb_wb_wavelet_bridge;
    localparam int          D    = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [7:0]  result_i;
    logic        result_valid_i;
    logic        irq_o;

    wb_wavelet_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .result_i      (result_i),
        .result_valid_i(result_valid_i),
        .irq_o         (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, registers are plain bits.
    logic [7:0]  m_q[$];
    bit          m_en, m_irq_en, m_ovf, m_rv, m_lost;
    logic [7:0]  m_res;
    bit          m_ack;
    logic [31:0] m_dat;
    bit          req_new;
    bit          rdy_pulse;

    function automatic logic [31:0] m_read(input logic [1:0] off);
        logic [31:0] v;
        v = '0;
        case (off)
            2'd0: begin v[0] = m_en; v[2] = m_irq_en; end
            2'd1: begin
                v[7:0] = 8'(m_q.size());
                v[8]   = (m_q.size() == 0);
                v[9]   = (m_q.size() == D);
                v[10]  = m_rv;
                v[11]  = m_ovf;
                v[12]  = m_lost;
            end
            2'd3: v[7:0] = m_res;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void model_step();
        bit         pop, hit, wr, rd;
        logic [1:0] off;
        int         sz;
        if (wb_rst_i) begin
            m_q.delete();
            m_en = 0; m_irq_en = 0; m_ovf = 0; m_rv = 0; m_lost = 0;
            m_res = '0; m_ack = 0; m_dat = '0;
            return;
        end
        sz  = m_q.size();
        pop = m_en && sz > 0 && sample_ready_i;
        hit = req_new && wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE[31:4]);
        off = wbs_adr_i[3:2];
        wr  = hit && wbs_we_i && wbs_sel_i[0];
        rd  = hit && !wbs_we_i;
        m_ack = hit;
        m_dat = rd ? m_read(off) : 32'd0;
        if (result_valid_i) begin
            if (m_rv && !(rd && off == 2'd3)) m_lost = 1;
            m_res = result_i;
            m_rv  = 1;
        end else if (rd && off == 2'd3) begin
            m_rv = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            case (off)
                2'd0: begin
                    m_en     = wbs_dat_i[0];
                    m_irq_en = wbs_dat_i[2];
                    if (wbs_dat_i[1]) m_q.delete();
                end
                2'd1: begin
                    if (wbs_dat_i[11]) m_ovf  = 0;
                    if (wbs_dat_i[12]) m_lost = 0;
                end
                2'd2: begin
                    if (sz < D || pop) m_q.push_back(wbs_dat_i[7:0]);
                    else               m_ovf = 1;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_outputs();
        check("ack", {31'd0, wbs_ack_o}, {31'd0, m_ack});
        check("dat", wbs_dat_o, m_dat);
        check("valid", {31'd0, sample_valid_o}, {31'd0, (m_en && m_q.size() > 0)});
        if (m_q.size() > 0) check("head", {24'd0, sample_o}, {24'd0, m_q[0]});
        check("irq", {31'd0, irq_o}, {31'd0, (m_irq_en && m_rv)});
    endtask

    task automatic step();
        model_step();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check_outputs();
        req_new        = 0;
        result_valid_i = 0;
    endtask

    task automatic bus(input bit we, input logic [1:0] off, input logic [31:0] dat,
                       input bit sel0, output logic [31:0] rd, output logic [7:0] smp);
        wbs_adr_i = BASE | {28'd0, off, 2'b00};
        wbs_we_i  = we;
        wbs_dat_i = dat;
        wbs_sel_i = {3'b111, sel0};
        wbs_stb_i = 1; wbs_cyc_i = 1; req_new = 1;
        step();
        rd  = wbs_dat_o;
        smp = sample_o;
        if (rdy_pulse) begin sample_ready_i = 0; rdy_pulse = 0; end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        step();
        step();
    endtask

    logic [31:0] rd_unused, rdv;
    logic [7:0]  smp_unused, smp;

    task automatic wr(input logic [1:0] off, input logic [31:0] dat);
        bus(1, off, dat, 1, rd_unused, smp_unused);
    endtask

    task automatic rdreg(input logic [1:0] off, output logic [31:0] v);
        bus(0, off, 32'd0, 1, v, smp_unused);
    endtask

    task automatic pulse_result(input logic [7:0] r);
        result_i = r; result_valid_i = 1;
        step();
    endtask

    initial begin
        wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0; sample_ready_i = 0; result_i = 0; result_valid_i = 0;
        req_new = 0; rdy_pulse = 0;
        step(); step();
        check("rst_sample", {24'd0, sample_o}, 32'd0);
        wb_rst_i = 0;
        step();

        rdreg(2'd1, rdv); check("status_rst", rdv, 32'h100);
        wbs_adr_i = 32'h2000_0000; wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1; req_new = 1;
        repeat (4) step();
        wbs_stb_i = 0; wbs_cyc_i = 0;
        step();

        sample_ready_i = 1;
        wr(2'd0, 32'h1);
        bus(1, 2'd2, 32'h11, 1, rdv, smp); check("fwft_11", {24'd0, smp}, 32'h11);
        bus(1, 2'd2, 32'h22, 1, rdv, smp); check("fwft_22", {24'd0, smp}, 32'h22);
        bus(1, 2'd2, 32'h33, 1, rdv, smp); check("fwft_33", {24'd0, smp}, 32'h33);
        rdreg(2'd1, rdv); check("drained", rdv, 32'h100);

        wr(2'd0, 32'h0);
        for (int i = 0; i < 3; i++) wr(2'd2, 32'h60 + i);
        wr(2'd0, 32'h1);
        step(); step();
        rdreg(2'd1, rdv); check("b2b_pop", rdv, 32'h100);

        sample_ready_i = 0;
        wr(2'd0, 32'h0);
        for (int i = 0; i < 9; i++) wr(2'd2, 32'h40 + i);
        rdreg(2'd1, rdv); check("ovf_full", rdv, 32'h0A08);
        wr(2'd1, 32'h800);
        rdreg(2'd1, rdv); check("ovf_w1c", rdv, 32'h0208);

        wr(2'd0, 32'h1);
        sample_ready_i = 1; rdy_pulse = 1;
        wr(2'd2, 32'h99);
        rdreg(2'd1, rdv); check("push_pop_full", rdv, 32'h0208);

        sample_ready_i = 1;
        repeat (3) step();
        sample_ready_i = 0;
        rdreg(2'd1, rdv); check("count5", rdv, 32'h0005);
        wr(2'd0, 32'h3);
        rdreg(2'd1, rdv); check("flushed", rdv, 32'h0100);
        wr(2'd2, 32'h77);
        rdreg(2'd1, rdv); check("after_flush_push", rdv, 32'h0001);
        bus(1, 2'd2, 32'h55, 0, rdv, smp);
        rdreg(2'd1, rdv); check("sel0_ignored", rdv, 32'h0001);

        wr(2'd0, 32'h5);
        pulse_result(8'h5A);
        check("irq_rise", {31'd0, irq_o}, 32'd1);
        pulse_result(8'hA5);
        rdreg(2'd1, rdv); check("lost", rdv, 32'h1401);
        rdreg(2'd3, rdv); check("result", rdv, 32'hA5);
        check("irq_fall", {31'd0, irq_o}, 32'd0);
        wr(2'd1, 32'h1000);
        rdreg(2'd1, rdv); check("lost_w1c", rdv, 32'h0001);
        pulse_result(8'h3C);
        result_i = 8'hC3; result_valid_i = 1;
        rdreg(2'd3, rdv); check("collide_old", rdv, 32'h3C);
        rdreg(2'd1, rdv); check("collide_stat", rdv, 32'h0401);
        rdreg(2'd3, rdv); check("collide_new", rdv, 32'hC3);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  off;
            logic [31:0] dat;
            bit          we;
            int          idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                sample_ready_i = 1'($urandom_range(0, 1));
                result_i       = 8'($urandom);
                result_valid_i = ($urandom_range(0, 4) == 0);
                step();
            end
            sample_ready_i = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            we  = ($urandom_range(0, 2) != 0);
            dat = $urandom;
            if (off == 2'd0) dat[1] = ($urandom_range(0, 7) == 0);
            bus(we, off, dat, ($urandom_range(0, 7) != 0), rd_unused, smp_unused);
        end

        wbs_adr_i = BASE | 32'h4; wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1; req_new = 1;
        wb_rst_i = 1;
        step(); step();
        wbs_stb_i = 0; wbs_cyc_i = 0; wb_rst_i = 0;
        step(); step();
        rdreg(2'd1, rdv); check("status_rst2", rdv, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_wavelet_bridge.md
# wb_wavelet_bridge

Wishbone classic responder that lets the management core stream 8-bit samples into the fuzzy wavelet core and read back its results, replacing the io-pad-only path. It sits in the user project wrapper between the Caravel Wishbone slave port and the wavelet core's sample/result ports. It provides a sample FIFO, a valid/ready output stream, a result capture register and a level interrupt.

## Interface
- BASE_ADDR, 32'h3000_0000, window base; decode is `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- FIFO_DEPTH, 8, sample FIFO depth; power of two, minimum 2.
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable.
- wbs_sel_i  in  4  byte selects; only bit 0 is used.
- wbs_adr_i, wbs_dat_i  in  32 each  Wishbone address and write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- sample_o  out  8  FIFO head sample.
- sample_valid_o  out  1  sample_o is valid.
- sample_ready_i  in  1  wavelet core accepts the sample.
- result_i  in  8  wavelet result.
- result_valid_i  in  1  one-cycle result strobe.
- irq_o  out  1  level interrupt (routed to user_irq[0]).

## Operation
- Register map, word offsets `wbs_adr_i[3:2]`:
  - 0x0 CTRL (RW): bit0 enable, bit1 flush (write-1, self-clearing, reads 0), bit2 irq_en.
  - 0x4 STATUS (R): [7:0] count, bit8 empty, bit9 full, bit10 result_valid, bit11 overflow, bit12 result_lost. Writing 1 to bit11 or bit12 clears that flag (W1C).
  - 0x8 SAMPLE (W): `wbs_dat_i[7:0]` is pushed to the FIFO. Reads return 0.
  - 0xC RESULT (R): [7:0] last captured result, upper bits 0. Reading clears result_valid.
- Writes take effect only when `wbs_sel_i[0]=1`. Otherwise the write is acked with no side effect.
- Requests outside the window are never acked and drive `wbs_dat_o=0`.
- FIFO behaviour:
  - The FIFO is first-word-fall-through.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push into a full FIFO with no simultaneous pop is dropped and sets overflow.
  - Flush empties the FIFO.
  - If flush and push occur in the same cycle, flush wins: the sample is discarded and overflow is not set.
  - Read and write pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
- Output stream:
  - `sample_valid_o = enable & ~empty`. `sample_o` is the FIFO head.
  - A pop occurs on a cycle where `sample_valid_o & sample_ready_i`.
  - Clearing enable drops valid immediately. The head sample is retained.
- Result capture:
  - On `result_valid_i`, RESULT is loaded from `result_i` and result_valid is set.
  - If result_valid was already 1, result_lost is also set.
  - If a new result arrives in the same cycle as a RESULT read, the new value is loaded, result_valid stays 1 and result_lost is not set. The read returns the old value.
- `irq_o = irq_en & result_valid`.
- Reset clears all state:
  - CTRL is 0 and the FIFO is empty.
  - All flags and RESULT are 0.
  - `wbs_ack_o=0`, `wbs_dat_o=0`, `sample_valid_o=0`, `sample_o=0`, `irq_o=0`.
  - A bus cycle in progress when reset asserts is abandoned without ack.

## Timing
- Handshake FSM states:
  - IDLE: on `stb & cyc & match`, go to ACK.
  - ACK: `wbs_ack_o=1` for exactly one cycle, then go to WAIT.
  - WAIT: go to IDLE once `stb` is low. This guarantees one ack per strobe.
- Latency: ack is asserted on the cycle after the request is sampled.
- Register side effects (push, W1C, CTRL load, read-clear) commit on the same edge that raises ack.
- `wbs_dat_o` is registered and valid while ack is high. It is 0 otherwise.
- STATUS reflects all updates made through the previous edge.
- A pushed sample appears on `sample_o` the cycle after the ack edge (sample_valid_o rises if enabled).
- Back-to-back pops are allowed at one per cycle.
- irq_o follows result_valid with no extra delay: it rises the cycle after `result_valid_i`, and falls the cycle after the RESULT read ack edge.

## Test plan
- Reset, then read STATUS -> ack 1 cycle after stb; data = 0x100 (empty). Read 0x2000_0000 -> never acked.
- Write CTRL=1, push samples 0x11, 0x22, 0x33 with sample_ready_i=1 -> sample_o shows 0x11, 0x22, 0x33 on consecutive valid cycles; count returns to 0.
- enable=0, push 9 samples with FIFO_DEPTH=8 -> STATUS = 0x0A08 (count 8, full, overflow). Write STATUS bit11 -> overflow clears; count stays 8.
- Full FIFO, enable=1 with ready=1, push in the same cycle as a pop -> push accepted, count stays 8, no overflow.
- With irq_en=1, drive result_valid_i with 0x5A -> irq_o=1. Send a second result 0xA5 before reading -> result_lost set. Read RESULT = 0xA5 -> irq_o falls.
- Write CTRL flush with sel[0]=1 while count=5, pushing in the next cycle -> count=0 after the flush edge, then 1.
